soc_system_sample_writer: RTL

Capture stage directly upstream of the on-chip RAM. It accepts a continuous stream of 16-bit signal samples, packs each pair of samples into one 32-bit word, and drives the RAM slave write port (address/byteenable/chipselect/write/writedata). It supports one-shot and circular capture windows so the HPS can read back sample records for reconstruction.

---
 rtl/soc_system_sample_writer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/soc_system_sample_writer.sv
// Packs pairs of 16-bit samples into 32-bit words and writes them to the on-chip RAM slave port.
// Optional build macro SAMPLE_WRITER_DROP_CNT_EN adds drop_count for samples seen while idle.
module soc_system_sample_writer #(
  parameter int ADDR_W   = 14,
  parameter int CNT_W    = 15,
  parameter int SAMPLE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SAMPLE_W-1:0]   sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  circular,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_words,
  output logic [ADDR_W-1:0]     address,
  output logic [3:0]            byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [2*SAMPLE_W-1:0] writedata,
  output logic                  clken,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap,
  output logic [1:0]            fsm_state,
`ifdef SAMPLE_WRITER_DROP_CNT_EN
  output logic [15:0]           drop_count,
`endif
  output logic [CNT_W-1:0]      wr_count
);

  // Stream handshake: a sample transfers on every cycle where sample_valid && sample_ready;
  // sample_ready is held at 1, so sample_valid alone marks a transfer.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LO    = 2'd1,
    S_HI    = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [ADDR_W-1:0]     cur_addr, cur_addr_d;
  logic [ADDR_W-1:0]     base_reg, base_d;
  logic [CNT_W-1:0]      num_reg, num_d;
  logic                  circ_reg, circ_d;
  logic [SAMPLE_W-1:0]   lo_reg, lo_d;
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W-1:0]      count_inc;
  logic [ADDR_W-1:0]     addr_d;
  logic [3:0]            be_d;
  logic                  wr_d;
  logic [2*SAMPLE_W-1:0] data_d;
  logic                  done_d;
  logic                  wrap_d;
  logic                  emit_full;
  logic                  emit_part;
  logic [SAMPLE_W-1:0]   part_sample;
  logic                  start_accept;
  logic                  wr_q;

  assign count_inc    = wr_count + 1'b1;
  assign start_accept = (state == S_IDLE) && start && !stop && (num_words != '0);

  always_comb begin
    state_d     = state;
    cur_addr_d  = cur_addr;
    base_d      = base_reg;
    num_d       = num_reg;
    circ_d      = circ_reg;
    lo_d        = lo_reg;
    count_d     = wr_count;
    addr_d      = address;
    data_d      = writedata;
    be_d        = 4'b0000;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    emit_full   = 1'b0;
    emit_part   = 1'b0;
    part_sample = lo_reg;

    case (state)
      S_IDLE: begin
        if (start_accept) begin
          base_d     = base_addr;
          num_d      = num_words;
          circ_d     = circular;
          cur_addr_d = base_addr;
          count_d    = '0;
          state_d    = S_LO;
        end
      end
      S_LO: begin
        if (stop) begin
          done_d = 1'b1;
          // A low sample arriving with stop is accepted first, then flushed alone.
          if (sample_valid) begin
            emit_part   = 1'b1;
            part_sample = sample_data;
            state_d     = S_FLUSH;
          end else begin
            state_d = S_IDLE;
          end
        end else if (sample_valid) begin
          lo_d    = sample_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (sample_valid) begin
          emit_full = 1'b1;
          if (stop) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (count_inc == num_reg) begin
            if (circ_reg) begin
              wrap_d  = 1'b1;
              state_d = S_LO;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_LO;
          end
        end else if (stop) begin
          emit_part = 1'b1;
          done_d    = 1'b1;
          state_d   = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (emit_full || emit_part) begin
      wr_d       = 1'b1;
      addr_d     = cur_addr;
      cur_addr_d = cur_addr + 1'b1;
      count_d    = count_inc;
      if (emit_full) begin
        be_d   = 4'b1111;
        data_d = {sample_data, lo_reg};
      end else begin
        be_d   = 4'b0011;
        data_d = {{SAMPLE_W{1'b0}}, part_sample};
      end
      // Circular reload happens in the same cycle as the write so no sample slot is lost.
      if (wrap_d) begin
        cur_addr_d = base_reg;
        count_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      base_reg   <= '0;
      num_reg    <= '0;
      circ_reg   <= 1'b0;
      lo_reg     <= '0;
      wr_count   <= '0;
      address    <= '0;
      byteenable <= 4'b0000;
      wr_q       <= 1'b0;
      writedata  <= '0;
      done       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_d;
      cur_addr   <= cur_addr_d;
      base_reg   <= base_d;
      num_reg    <= num_d;
      circ_reg   <= circ_d;
      lo_reg     <= lo_d;
      wr_count   <= count_d;
      address    <= addr_d;
      byteenable <= be_d;
      wr_q       <= wr_d;
      writedata  <= data_d;
      done       <= done_d;
      wrap       <= wrap_d;
    end
  end

`ifdef SAMPLE_WRITER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (start_accept) begin
      drop_count <= '0;
    end else if ((state == S_IDLE) && sample_valid && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

  // A finishing window returns to IDLE on the write edge; done keeps busy up for that cycle.
  assign busy         = (state != S_IDLE) || done;
  assign write        = wr_q;
  assign chipselect   = wr_q;
  assign sample_ready = 1'b1;
  assign clken        = 1'b1;
  assign fsm_state    = state;

endmodule
